asynchronous_fifo_controller_levels: RTL

Next-generation dual-clock FIFO controller for clock-domain crossing. It drives an external dual-port memory through gray-coded pointers and multi-stage synchronizers. Beyond plain full/empty, it adds per-domain fill levels, programmable almost-full/almost-empty flags, and overflow/underflow protection. It sits between a producer in the write_clock domain and a consumer in the read_clock domain.

---
 rtl/asynchronous_fifo_controller_levels.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/asynchronous_fifo_controller_levels.sv
// ---------------------------------------------------------------------------
// asynchronous_fifo_controller_levels
//
// Dual-clock FIFO controller for an external dual-port memory. Binary
// pointers with a wrap bit are kept in each domain. Their registered gray
// copies are the only signals that cross domains, each through a
// STAGES-deep synchronizer. Each domain reports a conservative fill level:
// the write side may over-report and the read side may under-report, so
// neither side can overrun nor over-read the memory.
//
// Optional feature (macro ASYNCHRONOUS_FIFO_CONTROLLER_LEVELS_ERROR_FLAGS_EN):
//   sticky write_overflow / read_underflow flags with clear inputs. When the
//   macro is undefined, both flags are tied low and the clear inputs are
//   unused.
//
// Ports
//   write_clock, write_resetn     write domain clock, async active-low reset
//   write_enable, write_data      push request and data
//   write_full, write_almost_full write-domain full / level >= AF threshold
//   write_level                   write-domain occupancy 0..DEPTH
//   write_overflow(_clear)        sticky push-while-full flag and its clear
//   read_clock, read_resetn       read domain clock, async active-low reset
//   read_enable, read_data        pop request, show-ahead head data
//   read_empty, read_almost_empty read-domain empty / level <= AE threshold
//   read_level                    read-domain occupancy
//   read_underflow(_clear)        sticky pop-while-empty flag and its clear
//   memory_write_*                external memory write port
//   memory_read_*                 external memory read port (async read data)
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module asynchronous_fifo_controller_levels #(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 16,
  parameter int STAGES                 = 2,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  localparam int DEPTH_LOG2            = $clog2(DEPTH)
) (
  input  logic                  write_clock,
  input  logic                  write_resetn,
  input  logic                  write_enable,
  input  logic [WIDTH-1:0]      write_data,
  output logic                  write_full,
  output logic                  write_almost_full,
  output logic [DEPTH_LOG2:0]   write_level,
  output logic                  write_overflow,
  input  logic                  write_overflow_clear,
  input  logic                  read_clock,
  input  logic                  read_resetn,
  input  logic                  read_enable,
  output logic [WIDTH-1:0]      read_data,
  output logic                  read_empty,
  output logic                  read_almost_empty,
  output logic [DEPTH_LOG2:0]   read_level,
  output logic                  read_underflow,
  input  logic                  read_underflow_clear,
  output logic                  memory_write_clock,
  output logic                  memory_write_enable,
  output logic [DEPTH_LOG2-1:0] memory_write_address,
  output logic [WIDTH-1:0]      memory_write_data,
  output logic                  memory_read_clock,
  output logic                  memory_read_enable,
  output logic [DEPTH_LOG2-1:0] memory_read_address,
  input  logic [WIDTH-1:0]      memory_read_data
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] AF_T = PW'(ALMOST_FULL_THRESHOLD);
  localparam logic [PW-1:0] AE_T = PW'(ALMOST_EMPTY_THRESHOLD);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int unsigned i = 1; i < PW; i++) begin
      b[PW-1-i] = b[PW-i] ^ g[PW-1-i];
    end
    return b;
  endfunction

  // ---------------- write domain ----------------
  logic [PW-1:0]             r_write_pointer;
  logic [PW-1:0]             r_write_gray;
  logic [STAGES-1:0][PW-1:0] r_read_gray_sync;   // [0] newest, [STAGES-1] oldest
  logic [PW-1:0]             w_read_gray_synced;
  logic [PW-1:0]             w_read_pointer_sync;
  logic [PW-1:0]             w_write_pointer_next;
  logic                      w_write_full;
  logic                      w_write_push;
  logic [PW-1:0]             w_write_level;

  assign w_read_gray_synced   = r_read_gray_sync[STAGES-1];
  assign w_read_pointer_sync  = gray2bin(w_read_gray_synced);
  assign w_write_pointer_next = r_write_pointer + PW'(1);
  // Full when the pointers differ by exactly DEPTH: in gray this is the
  // synchronized read gray with its two top bits inverted.
  assign w_write_full  = (r_write_gray == {~w_read_gray_synced[PW-1:PW-2],
                                           w_read_gray_synced[PW-3:0]});
  assign w_write_push  = write_enable & ~w_write_full;
  assign w_write_level = r_write_pointer - w_read_pointer_sync;

  always_ff @(posedge write_clock or negedge write_resetn) begin
    if (!write_resetn) begin
      r_write_pointer  <= '0;
      r_write_gray     <= '0;
      r_read_gray_sync <= '0;
    end else begin
      r_read_gray_sync <= {r_read_gray_sync[STAGES-2:0], r_read_gray};
      if (w_write_push) begin
        r_write_pointer <= w_write_pointer_next;
        r_write_gray    <= bin2gray(w_write_pointer_next);
      end
    end
  end

  assign write_full           = w_write_full;
  assign write_level          = w_write_level;
  assign write_almost_full    = (w_write_level >= AF_T);
  assign memory_write_clock   = write_clock;
  assign memory_write_enable  = w_write_push;
  assign memory_write_address = r_write_pointer[DEPTH_LOG2-1:0];
  assign memory_write_data    = write_data;

  // ---------------- read domain ----------------
  logic [PW-1:0]             r_read_pointer;
  logic [PW-1:0]             r_read_gray;
  logic [STAGES-1:0][PW-1:0] r_write_gray_sync;
  logic [PW-1:0]             w_write_gray_synced;
  logic [PW-1:0]             w_write_pointer_sync;
  logic [PW-1:0]             w_read_pointer_next;
  logic                      w_read_empty;
  logic                      w_read_pop;
  logic [PW-1:0]             w_read_level;

  assign w_write_gray_synced  = r_write_gray_sync[STAGES-1];
  assign w_write_pointer_sync = gray2bin(w_write_gray_synced);
  assign w_read_pointer_next  = r_read_pointer + PW'(1);
  assign w_read_empty         = (r_read_gray == w_write_gray_synced);
  assign w_read_pop           = read_enable & ~w_read_empty;
  assign w_read_level         = w_write_pointer_sync - r_read_pointer;

  always_ff @(posedge read_clock or negedge read_resetn) begin
    if (!read_resetn) begin
      r_read_pointer    <= '0;
      r_read_gray       <= '0;
      r_write_gray_sync <= '0;
    end else begin
      r_write_gray_sync <= {r_write_gray_sync[STAGES-2:0], r_write_gray};
      if (w_read_pop) begin
        r_read_pointer <= w_read_pointer_next;
        r_read_gray    <= bin2gray(w_read_pointer_next);
      end
    end
  end

  assign read_empty          = w_read_empty;
  assign read_level          = w_read_level;
  assign read_almost_empty   = (w_read_level <= AE_T);
  assign memory_read_clock   = read_clock;
  assign memory_read_enable  = ~w_read_empty;
  assign memory_read_address = r_read_pointer[DEPTH_LOG2-1:0];
  assign read_data           = memory_read_data;

  // ---------------- error flags ----------------
`ifdef ASYNCHRONOUS_FIFO_CONTROLLER_LEVELS_ERROR_FLAGS_EN
  logic r_write_overflow;
  logic r_read_underflow;

  // Set has priority over clear when both happen in the same cycle.
  always_ff @(posedge write_clock or negedge write_resetn) begin
    if (!write_resetn)                    r_write_overflow <= 1'b0;
    else if (write_enable & w_write_full) r_write_overflow <= 1'b1;
    else if (write_overflow_clear)        r_write_overflow <= 1'b0;
  end

  always_ff @(posedge read_clock or negedge read_resetn) begin
    if (!read_resetn)                    r_read_underflow <= 1'b0;
    else if (read_enable & w_read_empty) r_read_underflow <= 1'b1;
    else if (read_underflow_clear)       r_read_underflow <= 1'b0;
  end

  assign write_overflow = r_write_overflow;
  assign read_underflow = r_read_underflow;
`else
  logic w_unused_clears;
  assign w_unused_clears = &{1'b0, write_overflow_clear, read_underflow_clear};
  assign write_overflow  = 1'b0;
  assign read_underflow  = 1'b0;
`endif

endmodule
